// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: converts single-cycle SRAM-style core accesses (MEM stage)
// into handshaked sram_like transactions, stalls the pipeline while a
// transaction is in flight, and holds read data until the pipeline releases.
module d_sram_to_sram_like #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    // core SRAM-style port
    input  logic              data_sram_en,
    input  logic [DW/8-1:0]   data_sram_wen,
    input  logic [AW-1:0]     data_sram_addr,
    input  logic [DW-1:0]     data_sram_wdata,
    output logic [DW-1:0]     data_sram_rdata,
    // hazard unit
    output logic              d_stall,
    input  logic              longest_stall,
    // sram_like bus
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [AW-1:0]     data_addr,
    output logic [DW-1:0]     data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DW-1:0]     data_rdata
);

    localparam int unsigned BW = DW / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_wr;
    logic [DW-1:0] r_rdata;

    logic          w_req_phase;
    logic          w_addr_acc_now;
    logic          w_addr_acc;
    logic          w_done;
    logic          w_wr_cur;
    logic          w_txn_wr;
    logic          w_rd_done;
    logic [1:0]    w_size;

    // Request may only be presented before the address has been accepted.
    assign w_req_phase    = (r_state == S_IDLE) || (r_state == S_ADDR);
    assign w_addr_acc_now = w_req_phase & data_sram_en & data_addr_ok;
    // Address accepted in an earlier cycle (DATA) or in this one.
    assign w_addr_acc     = (r_state == S_DATA) | w_addr_acc_now;
    // data_ok counts only once an address is accepted; strays are ignored.
    assign w_done         = w_addr_acc & data_data_ok;
    assign w_wr_cur       = |data_sram_wen;
    // In DATA the core may have been flushed, so use the latched direction.
    assign w_txn_wr       = (r_state == S_DATA) ? r_wr : w_wr_cur;
    assign w_rd_done      = w_done & ~w_txn_wr;

    // Transfer size decode from the byte enables; odd patterns fall back to word.
    always_comb begin
        w_size = SZ_WORD;
        case (data_sram_wen)
            BW'(4'b1111), BW'(4'b0000): w_size = SZ_WORD;
            BW'(4'b0011), BW'(4'b1100): w_size = SZ_HALF;
            BW'(4'b0001), BW'(4'b0010),
            BW'(4'b0100), BW'(4'b1000): w_size = SZ_BYTE;
            default:                    w_size = SZ_WORD;
        endcase
    end

    // Bus request fields; address/data pass straight through from the core.
    assign data_req   = ~rst & data_sram_en & w_req_phase;
    assign data_wr    = w_wr_cur;
    assign data_size  = w_size;
    assign data_addr  = data_sram_addr;
    assign data_wdata = data_sram_wdata;

    // Stall until data_ok arrives; never stall while parked in DONE.
    assign d_stall = ~rst & data_sram_en & (r_state != S_DONE) & ~w_done;

    // Bypass read data in the completion cycle, otherwise present the held copy.
    assign data_sram_rdata = (~rst & w_rd_done) ? data_rdata : r_rdata;

    // Next-state logic for the single-outstanding transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ADDR: begin
                if (!data_sram_en) begin
                    w_state_nxt = S_IDLE;
                end else if (!data_addr_ok) begin
                    w_state_nxt = S_ADDR;
                end else if (data_data_ok) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (data_data_ok) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!longest_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch transaction direction when the address is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= 1'b0;
        end else if (w_addr_acc_now) begin
            r_wr <= w_wr_cur;
        end
    end

    // Capture read data on completion; writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_done) begin
            r_rdata <= data_rdata;
        end
    end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed self-checking bench for d_sram_to_sram_like.
module tb_d_sram_to_sram_like;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    d_sram_to_sram_like #(.AW(32), .DW(32)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .longest_stall   (longest_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic bus_quiet;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    task automatic core(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        longest_stall = 1'b0;
        bus_quiet();
        core(1'b1, 4'h0, 32'h0, 32'h0);
        settle();
        // reset state
        check("rst_req",   32'(data_req), 32'h0);
        check("rst_stall", 32'(d_stall), 32'h0);
        check("rst_rdata", data_sram_rdata, 32'h0);
        core(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("idle_req",   32'(data_req), 32'h0);
        check("idle_stall", 32'(d_stall), 32'h0);

        // word read: addr_ok cycle 0, data_ok cycle 2
        core(1'b1, 4'h0, 32'h1000, 32'h0);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        settle();
        check("rd_c0_req",   32'(data_req), 32'h1);
        check("rd_c0_size",  32'(data_size), 32'h2);
        check("rd_c0_wr",    32'(data_wr), 32'h0);
        check("rd_c0_addr",  data_addr, 32'h1000);
        check("rd_c0_stall", 32'(d_stall), 32'h1);
        next_cycle();
        data_addr_ok = 1'b0;
        settle();
        check("rd_c1_req",   32'(data_req), 32'h0);
        check("rd_c1_stall", 32'(d_stall), 32'h1);
        next_cycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        settle();
        check("rd_c2_req",   32'(data_req), 32'h0);
        check("rd_c2_stall", 32'(d_stall), 32'h0);
        check("rd_c2_rdata", data_sram_rdata, 32'hDEADBEEF);
        next_cycle();
        bus_quiet();
        settle();
        check("rd_hold_rdata", data_sram_rdata, 32'hDEADBEEF);
        check("rd_hold_req",   32'(data_req), 32'h0);
        check("rd_hold_stall", 32'(d_stall), 32'h0);
        next_cycle();
        longest_stall = 1'b0;
        settle();
        check("rd_rel_rdata", data_sram_rdata, 32'hDEADBEEF);
        next_cycle();
        core(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        check("rd_idle_req",   32'(data_req), 32'h0);
        check("rd_idle_rdata", data_sram_rdata, 32'hDEADBEEF);

        // byte write with addr_ok delayed three cycles
        next_cycle();
        core(1'b1, 4'b0100, 32'h2002, 32'h00AB0000);
        longest_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bw_wait_req",   32'(data_req), 32'h1);
            check("bw_wait_addr",  data_addr, 32'h2002);
            check("bw_wait_wdata", data_wdata, 32'h00AB0000);
            check("bw_wait_size",  32'(data_size), 32'h0);
            check("bw_wait_wr",    32'(data_wr), 32'h1);
            check("bw_wait_stall", 32'(d_stall), 32'h1);
            next_cycle();
        end
        data_addr_ok = 1'b1;
        settle();
        check("bw_acc_req",   32'(data_req), 32'h1);
        check("bw_acc_stall", 32'(d_stall), 32'h1);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h12345678;
        settle();
        check("bw_ok_req",   32'(data_req), 32'h0);
        check("bw_ok_stall", 32'(d_stall), 32'h0);
        check("bw_ok_rdata", data_sram_rdata, 32'hDEADBEEF);
        next_cycle();
        bus_quiet();
        longest_stall = 1'b0;
        settle();
        check("bw_done_rdata", data_sram_rdata, 32'hDEADBEEF);
        next_cycle();

        // same-cycle completion, then pipeline held by instrStall for 3 cycles
        core(1'b1, 4'h0, 32'h3000, 32'h0);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFEF00D;
        settle();
        check("sc_req",   32'(data_req), 32'h1);
        check("sc_stall", 32'(d_stall), 32'h0);
        check("sc_rdata", data_sram_rdata, 32'hCAFEF00D);
        next_cycle();
        bus_quiet();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("sc_hold_req",   32'(data_req), 32'h0);
            check("sc_hold_stall", 32'(d_stall), 32'h0);
            check("sc_hold_rdata", data_sram_rdata, 32'hCAFEF00D);
            next_cycle();
        end
        longest_stall = 1'b0;
        settle();
        check("sc_rel_req", 32'(data_req), 32'h0);
        next_cycle();

        // back-to-back half write (1100) completing in one cycle
        core(1'b1, 4'b1100, 32'h3004, 32'h55660000);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFFFFFF;
        settle();
        check("hw_req",   32'(data_req), 32'h1);
        check("hw_size",  32'(data_size), 32'h1);
        check("hw_wr",    32'(data_wr), 32'h1);
        check("hw_rdata", data_sram_rdata, 32'hCAFEF00D);
        next_cycle();
        bus_quiet();
        longest_stall = 1'b0;
        settle();
        check("hw_done_rdata", data_sram_rdata, 32'hCAFEF00D);
        next_cycle();

        // illegal byte-enable pattern falls back to a word write
        core(1'b1, 4'b0101, 32'h3008, 32'h01020304);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BADF00D;
        settle();
        check("il_size",  32'(data_size), 32'h2);
        check("il_wr",    32'(data_wr), 32'h1);
        check("il_rdata", data_sram_rdata, 32'hCAFEF00D);
        next_cycle();
        bus_quiet();
        longest_stall = 1'b0;
        next_cycle();

        // async reset while waiting for data_ok
        core(1'b1, 4'h0, 32'h4000, 32'h0);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        settle();
        check("ar_data_stall", 32'(d_stall), 32'h1);
        rst = 1'b1;
        settle();
        check("ar_req",   32'(data_req), 32'h0);
        check("ar_stall", 32'(d_stall), 32'h0);
        check("ar_rdata", data_sram_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        // stray data_ok with no accepted address is ignored
        data_data_ok = 1'b1;
        data_rdata   = 32'h77777777;
        settle();
        check("stray_req",   32'(data_req), 32'h1);
        check("stray_stall", 32'(d_stall), 32'h1);
        check("stray_rdata", data_sram_rdata, 32'h0);
        next_cycle();
        data_data_ok = 1'b0;
        settle();
        check("stray_after_req", 32'(data_req), 32'h1);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h5A5A5A5A;
        settle();
        check("ar_new_stall", 32'(d_stall), 32'h0);
        check("ar_new_rdata", data_sram_rdata, 32'h5A5A5A5A);
        next_cycle();
        bus_quiet();
        longest_stall = 1'b0;
        next_cycle();

        // flush: en drops while waiting for data_ok
        core(1'b1, 4'h0, 32'h6000, 32'h0);
        longest_stall = 1'b1;
        data_addr_ok = 1'b1;
        settle();
        check("fl_req", 32'(data_req), 32'h1);
        next_cycle();
        bus_quiet();
        core(1'b0, 4'h0, 32'h0, 32'h0);
        longest_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("fl_wait_req",   32'(data_req), 32'h0);
            check("fl_wait_stall", 32'(d_stall), 32'h0);
            next_cycle();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'h11112222;
        settle();
        check("fl_ok_req",   32'(data_req), 32'h0);
        check("fl_ok_stall", 32'(d_stall), 32'h0);
        next_cycle();
        bus_quiet();
        settle();
        check("fl_done_req", 32'(data_req), 32'h0);
        next_cycle();
        // back in IDLE: a fresh request issues immediately
        core(1'b1, 4'b1111, 32'h7000, 32'hA5A5A5A5);
        settle();
        check("fl_next_req",   32'(data_req), 32'h1);
        check("fl_next_size",  32'(data_size), 32'h2);
        check("fl_next_stall", 32'(d_stall), 32'h1);
        next_cycle();
        core(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/d_sram_to_sram_like.md
Name: d_sram_to_sram_like

Overview:
- Data-side bridge between the core's single-cycle SRAM-style memory port (MEM stage) and the handshaked sram_like bus toward the AXI interface.
- Converts each enabled core access into exactly one sram_like transaction.
- Generates dataStall back to the hazard unit and holds the returned read data until the whole pipeline releases, i.e. until longest_stall drops.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32, byte-enable width is DW/8 = 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- data_sram_en  in  1  core access request; held while the core is stalled
- data_sram_wen  in  4  byte write enables; 0 means read
- data_sram_addr  in  AW  byte address
- data_sram_wdata  in  DW  write data
- data_sram_rdata  out  DW  read data returned to the core
- d_stall  out  1  dataStall to the hazard unit
- longest_stall  in  1  global stall from the hazard unit
- data_req  out  1  sram_like request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  AW  request address
- data_wdata  out  DW  request write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / data valid
- data_rdata  in  DW  response data

Behaviour:
- States:
  - IDLE: no outstanding request.
  - ADDR: request presented, waiting for addr_ok.
  - DATA: accepted, waiting for data_ok.
  - DONE: transaction finished, holding result until the pipeline releases.
- Reset (async) forces:
  - state = IDLE
  - rdata register = 0, so data_sram_rdata = 0
  - data_req = 0 and d_stall = 0
- data_req is combinational: data_sram_en & (state==IDLE | state==ADDR). The request is visible in the same cycle en rises.
- Transitions:
  - IDLE -> ADDR on en & ~addr_ok.
  - IDLE -> DATA on en & addr_ok & ~data_ok.
  - IDLE -> DONE on en & addr_ok & data_ok (same-cycle completion).
  - ADDR behaves the same as IDLE, with en already known high.
  - DATA -> DONE on data_ok.
  - DONE -> IDLE on ~longest_stall.
- Request fields:
  - data_wr = |wen.
  - data_size:
    - wen 4'b1111 or 4'b0000 -> 2
    - 4'b0011 or 4'b1100 -> 1
    - one-hot -> 0
    - any other pattern -> 2
  - data_addr and data_wdata pass straight through from the core port.
  - Fields must stay stable while data_req=1 and addr_ok=0; the core guarantees this by holding its inputs while stalled.
- d_stall = data_sram_en & (state != DONE) & ~(state!=DONE & data_ok & (addr accepted this cycle or earlier)).
  - Equivalently, d_stall drops in the cycle data_ok arrives.
  - It stays low in DONE.
- Read data:
  - On data_ok with data_wr=0, capture data_rdata into the rdata register.
  - data_sram_rdata = data_rdata in the data_ok cycle (bypass); otherwise it is the register.
  - The register is held through DONE and until the next read completes.
  - Writes do not change the register.
- Single outstanding transaction only. A new request is never issued before DONE -> IDLE.
- data_ok seen in IDLE or ADDR state without an accepted address is ignored.
- Exceptions:
  - Once addr_ok is taken, the transaction always completes; there is no cancel.
  - If en drops while in DATA (pipeline flushed), the FSM still waits for data_ok, then goes to DONE and releases.
- en=0 in IDLE: no request, d_stall=0.
- longest_stall high because of instrStall or div while in DONE: stay in DONE, no re-issue, d_stall=0, rdata stable.
- Back-to-back accesses: after DONE -> IDLE, a new en in the following cycle issues a new request.

Test Plan:
- Word read: en=1, wen=0, addr=0x1000, addr_ok on cycle 0, data_ok on cycle 2 with rdata=0xDEADBEEF.
  - Required: req=1 only on cycle 0, size=2, wr=0.
  - Required: d_stall=1 on cycles 0-1 and 0 on cycle 2.
  - Required: data_sram_rdata=0xDEADBEEF from cycle 2 and held while longest_stall=1.
- Byte write: wen=4'b0100, addr=0x2002, wdata=0x00AB0000, addr_ok delayed 3 cycles, then data_ok.
  - Required: req held 4 cycles with stable fields, size=0, wr=1, d_stall=1 until data_ok.
- Same-cycle completion: addr_ok=data_ok=1 in the first cycle.
  - Required: d_stall=0 in that cycle, state DONE, and no second request while longest_stall=1 (instrStall held 3 cycles).
- Half write with wen=4'b1100 -> size=1.
  - Illegal wen=4'b0101 -> size=2, wr=1.
  - Write does not alter the previously read rdata.
- Async reset asserted while in DATA: req, d_stall and rdata go to 0 immediately. A stray data_ok after reset is ignored and the next request issues normally.
- Flush: en drops while in DATA, then data_ok 2 cycles later.
  - Required: no new req, return to IDLE after ~longest_stall, d_stall=0 throughout after en drops.
